uart_cmd_decoder: RTL and testbench

Byte-stream command parser sitting directly downstream of the UART receiver in the elevator controller. Consumes received bytes on their single-cycle completion strobe, decodes two-byte ASCII commands (opcode + floor digit) into one-cycle request pulses for the car-call and hall-call logic, and flags malformed or timed-out commands. Optionally returns a one-byte acknowledge through the UART sender.

---
 rtl/uart_cmd_pkg.sv | 52 +++++
 rtl/uart_cmd_timer.sv | 35 +++
 rtl/uart_cmd_decoder.sv | 174 +++++++++++++++++
 tb/tb_uart_cmd_decoder.sv | 288 ++++++++++++++++++++++++++++
 4 files changed

// File: rtl/uart_cmd_pkg.sv
// Shared constants, state encoding and byte-classification helpers for uart_cmd_decoder.
// The ACK state exists only when UART_CMD_ACK_EN is defined.
package uart_cmd_pkg;

  localparam logic [7:0] OPC_CAR_U  = 8'h43;
  localparam logic [7:0] OPC_CAR_L  = 8'h63;
  localparam logic [7:0] OPC_UP_U   = 8'h55;
  localparam logic [7:0] OPC_UP_L   = 8'h75;
  localparam logic [7:0] OPC_DOWN_U = 8'h44;
  localparam logic [7:0] OPC_DOWN_L = 8'h64;

  localparam logic [7:0] CH_CR     = 8'h0D;
  localparam logic [7:0] CH_LF     = 8'h0A;
  localparam logic [7:0] CH_SP     = 8'h20;
  localparam logic [7:0] CH_ACK    = 8'h21;
  localparam logic [7:0] CH_NAK    = 8'h3F;
  localparam logic [7:0] CH_DIGIT1 = 8'h31;

  localparam int unsigned BITS_PER_CHAR = 10;
  localparam int unsigned TMR_W         = 32;

  typedef enum logic [1:0] {
    ST_IDLE       = 2'd0,
    ST_WAIT_FLOOR = 2'd1,
    ST_EXEC       = 2'd2
`ifdef UART_CMD_ACK_EN
    ,
    ST_ACK        = 2'd3
`endif
  } state_t;

  typedef enum logic [1:0] {
    OP_NONE = 2'd0,
    OP_CAR  = 2'd1,
    OP_UP   = 2'd2,
    OP_DOWN = 2'd3
  } op_t;

  function automatic op_t decode_op(input logic [7:0] b);
    case (b)
      OPC_CAR_U,  OPC_CAR_L:  decode_op = OP_CAR;
      OPC_UP_U,   OPC_UP_L:   decode_op = OP_UP;
      OPC_DOWN_U, OPC_DOWN_L: decode_op = OP_DOWN;
      default:                decode_op = OP_NONE;
    endcase
  endfunction

  function automatic logic is_filler(input logic [7:0] b);
    return (b == CH_CR) || (b == CH_LF) || (b == CH_SP);
  endfunction

endpackage

// File: rtl/uart_cmd_timer.sv
// Loadable down-counter; expiry is flagged while armed and the count has reached zero.
module uart_cmd_timer
  import uart_cmd_pkg::*;
#(
  parameter int unsigned LOAD_VAL = 1000
) (
  input  logic clk,
  input  logic reset,
  input  logic i_load,
  input  logic i_clear,
  output logic o_expired_c
);

  logic [TMR_W-1:0] r_count;
  logic             r_armed;

  // Load wins over clear; an armed counter holds at zero until cleared.
  always_ff @(posedge clk) begin
    if (reset) begin
      r_count <= '0;
      r_armed <= 1'b0;
    end else if (i_load) begin
      r_count <= TMR_W'(LOAD_VAL);
      r_armed <= 1'b1;
    end else if (i_clear) begin
      r_count <= '0;
      r_armed <= 1'b0;
    end else if (r_armed && (r_count != '0)) begin
      r_count <= r_count - TMR_W'(1);
    end
  end

  assign o_expired_c = r_armed && (r_count == '0);

endmodule

// File: rtl/uart_cmd_decoder.sv
// Two-byte ASCII command parser (opcode + floor digit) producing one-cycle call pulses.
// Define UART_CMD_ACK_EN to add the tx acknowledge port and ACK state.
module uart_cmd_decoder
  import uart_cmd_pkg::*;
#(
  parameter int unsigned CLKFRQ        = 100000000,
  parameter int unsigned BAUDRATE      = 9600,
  parameter int unsigned FLOORS        = 7,
  parameter int unsigned TIMEOUT_CHARS = 16
) (
  input  logic              clk,
  input  logic              reset,
  input  logic [7:0]        rx_data,
  input  logic              rx_valid,
  output logic [FLOORS-1:0] car_call,
  output logic [FLOORS-1:0] hall_up,
  output logic [FLOORS-1:0] hall_down,
  output logic              cmd_error,
`ifdef UART_CMD_ACK_EN
  output logic [7:0]        tx_data,
  output logic              tx_en,
  input  logic              tx_ready,
`endif
  output logic              busy
);

  localparam int unsigned TIMEOUT_CYCLES = TIMEOUT_CHARS * BITS_PER_CHAR * (CLKFRQ / BAUDRATE);

  state_t            r_state, w_next_state;
  op_t               r_op, w_op_next, w_rx_op;
  logic [3:0]        r_floor, w_floor_next, w_digit_idx;
  logic [FLOORS-1:0] r_car, r_up, r_down, w_car, w_up, w_down;
  logic              r_err, r_busy;
  logic              w_fire, w_err, w_timer_load, w_timer_clear, w_expired;
  logic              w_digit_ok, w_dir_ok;
`ifdef UART_CMD_ACK_EN
  logic [7:0]        r_ack_char, w_ack_char_next;
`endif

  uart_cmd_timer #(.LOAD_VAL(TIMEOUT_CYCLES)) u_timer (
    .clk         (clk),
    .reset       (reset),
    .i_load      (w_timer_load),
    .i_clear     (w_timer_clear),
    .o_expired_c (w_expired)
  );

  // Byte classification; direction check rejects up from the top floor and down from floor 1.
  assign w_rx_op     = decode_op(rx_data);
  assign w_digit_idx = 4'(rx_data - CH_DIGIT1);
  assign w_digit_ok  = (rx_data >= CH_DIGIT1) && (rx_data <= 8'(8'h30 + FLOORS));
  assign w_dir_ok    = !(((r_op == OP_UP) && (w_digit_idx == 4'(FLOORS - 1))) ||
                         ((r_op == OP_DOWN) && (w_digit_idx == 4'd0)));

  always_ff @(posedge clk) begin
    if (reset) begin
      r_state    <= ST_IDLE;
      r_op       <= OP_NONE;
      r_floor    <= '0;
      r_car      <= '0;
      r_up       <= '0;
      r_down     <= '0;
      r_err      <= 1'b0;
      r_busy     <= 1'b0;
`ifdef UART_CMD_ACK_EN
      r_ack_char <= '0;
`endif
    end else begin
      r_state    <= w_next_state;
      r_op       <= w_op_next;
      r_floor    <= w_floor_next;
      r_car      <= w_car;
      r_up       <= w_up;
      r_down     <= w_down;
      r_err      <= w_err;
      r_busy     <= (w_next_state != ST_IDLE);
`ifdef UART_CMD_ACK_EN
      r_ack_char <= w_ack_char_next;
`endif
    end
  end

  always_comb begin
    w_next_state  = r_state;
    w_op_next     = r_op;
    w_floor_next  = r_floor;
    w_fire        = 1'b0;
    w_err         = 1'b0;
    w_timer_load  = 1'b0;
    w_timer_clear = 1'b0;
`ifdef UART_CMD_ACK_EN
    w_ack_char_next = r_ack_char;
`endif
    case (r_state)
      ST_IDLE: begin
        if (rx_valid) begin
          if (w_rx_op != OP_NONE) begin
            w_op_next    = w_rx_op;
            w_next_state = ST_WAIT_FLOOR;
            w_timer_load = 1'b1;
          end else if (!is_filler(rx_data)) begin
            w_err = 1'b1;
          end
        end
      end
      ST_WAIT_FLOOR: begin
        // A byte in the expiry cycle takes precedence over the timeout.
        if (rx_valid) begin
          w_timer_clear = 1'b1;
          if (w_digit_ok && w_dir_ok) begin
            w_floor_next = w_digit_idx;
            w_fire       = 1'b1;
            w_next_state = ST_EXEC;
          end else begin
            w_err = 1'b1;
          end
        end else if (w_expired) begin
          w_timer_clear = 1'b1;
          w_err         = 1'b1;
        end
      end
      ST_EXEC: begin
`ifdef UART_CMD_ACK_EN
        w_next_state    = ST_ACK;
        w_ack_char_next = CH_ACK;
`else
        w_next_state    = ST_IDLE;
`endif
      end
`ifdef UART_CMD_ACK_EN
      ST_ACK: begin
        if (tx_ready) w_next_state = ST_IDLE;
      end
`endif
      default: w_next_state = ST_IDLE;
    endcase
    if (w_err) begin
`ifdef UART_CMD_ACK_EN
      w_next_state    = ST_ACK;
      w_ack_char_next = CH_NAK;
`else
      w_next_state    = ST_IDLE;
`endif
    end
  end

  // Request vectors are computed alongside the EXEC transition and registered into EXEC.
  always_comb begin
    w_car  = '0;
    w_up   = '0;
    w_down = '0;
    if (w_fire) begin
      case (r_op)
        OP_CAR:  w_car  = FLOORS'(1) << w_floor_next;
        OP_UP:   w_up   = FLOORS'(1) << w_floor_next;
        OP_DOWN: w_down = FLOORS'(1) << w_floor_next;
        default: ;
      endcase
    end
  end

  assign car_call  = r_car;
  assign hall_up   = r_up;
  assign hall_down = r_down;
  assign cmd_error = r_err;
  assign busy      = r_busy;

`ifdef UART_CMD_ACK_EN
  // Send request is gated by the sender's ready so it can only fire in an accepted cycle.
  assign tx_data = r_ack_char;
  assign tx_en   = (r_state == ST_ACK) && tx_ready;
`endif

endmodule

// File: tb/tb_uart_cmd_decoder.sv
// Self-checking bench for uart_cmd_decoder: directed vector table, corner sequences and random bytes vs a model.
// Covers the ACK path when UART_CMD_ACK_EN is defined.
module tb_uart_cmd_decoder;

  localparam int unsigned CLKFRQ        = 1000;
  localparam int unsigned BAUDRATE      = 100;
  localparam int unsigned FLOORS        = 7;
  localparam int unsigned TIMEOUT_CHARS = 2;
  localparam int          TMO           = TIMEOUT_CHARS * 10 * (CLKFRQ / BAUDRATE);
`ifdef UART_CMD_ACK_EN
  localparam bit ACK_EN = 1'b1;
`else
  localparam bit ACK_EN = 1'b0;
`endif

  logic              clk = 1'b0;
  logic              reset = 1'b1;
  logic [7:0]        rx_data = '0;
  logic              rx_valid = 1'b0;
  logic [FLOORS-1:0] car_call, hall_up, hall_down;
  logic              cmd_error, busy;
  bit                rdy_drv = 1'b1;
`ifdef UART_CMD_ACK_EN
  logic [7:0]        tx_data;
  logic              tx_en;
  logic              tx_ready;
  assign tx_ready = rdy_drv;
`endif

  int errors = 0;
  int checks = 0;

  always #5 clk = ~clk;

  uart_cmd_decoder #(
    .CLKFRQ(CLKFRQ), .BAUDRATE(BAUDRATE), .FLOORS(FLOORS), .TIMEOUT_CHARS(TIMEOUT_CHARS)
  ) dut (
    .clk(clk), .reset(reset), .rx_data(rx_data), .rx_valid(rx_valid),
    .car_call(car_call), .hall_up(hall_up), .hall_down(hall_down),
    .cmd_error(cmd_error),
`ifdef UART_CMD_ACK_EN
    .tx_data(tx_data), .tx_en(tx_en), .tx_ready(tx_ready),
`endif
    .busy(busy)
  );

  // Reference model: pending opcode character, cycles since it arrived, and post-command phases.
  logic [7:0]        m_op = '0;
  int                m_age = 0;
  bit                m_exec = 1'b0;
  bit                m_ack = 1'b0;
  logic [7:0]        m_ack_chr = '0;
  logic [FLOORS-1:0] e_car = '0, e_up = '0, e_down = '0;
  bit                e_err = 1'b0, e_busy = 1'b0;

  function automatic bit is_op(input logic [7:0] b);
    return b inside {8'h43, 8'h63, 8'h55, 8'h75, 8'h44, 8'h64};
  endfunction

  task automatic reject();
    e_err = 1'b1;
    m_op  = '0;
    if (ACK_EN) begin
      m_ack     = 1'b1;
      m_ack_chr = 8'h3F;
    end
  endtask

  task automatic model_edge(input bit rst, input bit v, input logic [7:0] d, input bit rdy);
    int fl;
    bit up, dn;
    e_car = '0; e_up = '0; e_down = '0; e_err = 1'b0;
    if (rst) begin
      m_op = '0; m_exec = 1'b0; m_ack = 1'b0; m_ack_chr = '0;
    end else if (m_exec) begin
      m_exec = 1'b0;
      if (ACK_EN) begin
        m_ack     = 1'b1;
        m_ack_chr = 8'h21;
      end
    end else if (m_ack) begin
      if (rdy) m_ack = 1'b0;
    end else if (m_op == 8'h00) begin
      if (v) begin
        if (is_op(d)) begin
          m_op  = d;
          m_age = 0;
        end else if (!(d inside {8'h0D, 8'h0A, 8'h20})) begin
          reject();
        end
      end
    end else begin
      m_age++;
      if (v) begin
        fl = int'(d) - 48;
        up = m_op inside {8'h55, 8'h75};
        dn = m_op inside {8'h44, 8'h64};
        if (fl >= 1 && fl <= int'(FLOORS) && !(up && fl == int'(FLOORS)) && !(dn && fl == 1)) begin
          if (up)      e_up[fl-1]   = 1'b1;
          else if (dn) e_down[fl-1] = 1'b1;
          else         e_car[fl-1]  = 1'b1;
          m_exec = 1'b1;
          m_op   = '0;
        end else begin
          reject();
        end
      end else if (m_age == TMO + 1) begin
        reject();
      end
    end
    e_busy = (m_op != 8'h00) || m_exec || m_ack;
  endtask

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
    end
  endtask

  task automatic check_model();
    chk("car_call", 32'(car_call), 32'(e_car));
    chk("hall_up", 32'(hall_up), 32'(e_up));
    chk("hall_down", 32'(hall_down), 32'(e_down));
    chk("cmd_error", 32'(cmd_error), 32'(e_err));
    chk("busy", 32'(busy), 32'(e_busy));
    chk("one_request", 32'($countones({car_call, hall_up, hall_down}) <= 1), 32'(1));
`ifdef UART_CMD_ACK_EN
    chk("tx_en", 32'(tx_en), 32'(m_ack && rdy_drv));
    if (m_ack) chk("tx_data", 32'(tx_data), 32'(m_ack_chr));
`endif
  endtask

  // One clock: drive after the falling edge, let the model see the rising edge, sample at the next falling edge.
  task automatic cyc(input bit rst, input bit v, input logic [7:0] d);
    reset    = rst;
    rx_valid = v;
    rx_data  = v ? d : 8'($urandom);
    @(posedge clk);
    model_edge(rst, v, d, rdy_drv);
    @(negedge clk);
    check_model();
  endtask

  typedef struct {
    bit         v;
    logic [7:0] d;
    logic [6:0] car;
    logic [6:0] up;
    logic [6:0] down;
    bit         err;
    bit         bsy;
  } vec_t;

  function automatic vec_t mk(input bit v, input logic [7:0] d, input logic [6:0] c,
                              input logic [6:0] u, input logic [6:0] dn, input bit e, input bit b);
    vec_t r;
    r.v = v; r.d = d; r.car = c; r.up = u; r.down = dn; r.err = e; r.bsy = b;
    return r;
  endfunction

  vec_t tbl[$];

  initial begin
    tbl.push_back(mk(1, 8'h43, 7'h00, 7'h00, 7'h00, 0, 1));      // 'C'
    tbl.push_back(mk(1, 8'h33, 7'b0000100, 7'h00, 7'h00, 0, 1)); // '3'
    tbl.push_back(mk(0, 8'h00, 7'h00, 7'h00, 7'h00, 0, 0));
    tbl.push_back(mk(1, 8'h75, 7'h00, 7'h00, 7'h00, 0, 1));      // 'u'
    tbl.push_back(mk(1, 8'h37, 7'h00, 7'h00, 7'h00, 1, 0));      // '7'
    tbl.push_back(mk(1, 8'h64, 7'h00, 7'h00, 7'h00, 0, 1));      // 'd'
    tbl.push_back(mk(1, 8'h31, 7'h00, 7'h00, 7'h00, 1, 0));      // '1'
    tbl.push_back(mk(1, 8'h0D, 7'h00, 7'h00, 7'h00, 0, 0));      // CR
    tbl.push_back(mk(1, 8'h58, 7'h00, 7'h00, 7'h00, 1, 0));      // 'X'
    tbl.push_back(mk(1, 8'h43, 7'h00, 7'h00, 7'h00, 0, 1));      // 'C'
    tbl.push_back(mk(1, 8'h38, 7'h00, 7'h00, 7'h00, 1, 0));      // '8'
    tbl.push_back(mk(1, 8'h44, 7'h00, 7'h00, 7'h00, 0, 1));      // 'D'
    tbl.push_back(mk(1, 8'h35, 7'h00, 7'h00, 7'b0010000, 0, 1)); // '5'
    tbl.push_back(mk(1, 8'h55, 7'h00, 7'h00, 7'h00, 0, 0));      // dropped in EXEC
    tbl.push_back(mk(1, 8'h20, 7'h00, 7'h00, 7'h00, 0, 0));      // space
    tbl.push_back(mk(1, 8'h0A, 7'h00, 7'h00, 7'h00, 0, 0));      // LF
    tbl.push_back(mk(1, 8'h63, 7'h00, 7'h00, 7'h00, 0, 1));      // 'c'
    tbl.push_back(mk(1, 8'h32, 7'b0000010, 7'h00, 7'h00, 0, 1)); // '2'
    tbl.push_back(mk(0, 8'h00, 7'h00, 7'h00, 7'h00, 0, 0));

    @(negedge clk);
    cyc(1, 0, 8'h00);
    cyc(1, 0, 8'h00);
    chk("reset_car", 32'(car_call), 32'(0));
    chk("reset_up", 32'(hall_up), 32'(0));
    chk("reset_down", 32'(hall_down), 32'(0));
    chk("reset_err", 32'(cmd_error), 32'(0));
    chk("reset_busy", 32'(busy), 32'(0));

`ifndef UART_CMD_ACK_EN
    foreach (tbl[i]) begin
      cyc(0, tbl[i].v, tbl[i].d);
      chk($sformatf("vec%0d_car", i), 32'(car_call), 32'(tbl[i].car));
      chk($sformatf("vec%0d_up", i), 32'(hall_up), 32'(tbl[i].up));
      chk($sformatf("vec%0d_down", i), 32'(hall_down), 32'(tbl[i].down));
      chk($sformatf("vec%0d_err", i), 32'(cmd_error), 32'(tbl[i].err));
      chk($sformatf("vec%0d_busy", i), 32'(busy), 32'(tbl[i].bsy));
    end

    // Timeout after 'D', then a clean 'D','5'.
    cyc(0, 1, 8'h44);
    for (int j = 1; j <= TMO; j++) cyc(0, 0, 8'h00);
    chk("tmo_busy_before", 32'(busy), 32'(1));
    chk("tmo_no_early_err", 32'(cmd_error), 32'(0));
    cyc(0, 0, 8'h00);
    chk("tmo_err", 32'(cmd_error), 32'(1));
    chk("tmo_idle", 32'(busy), 32'(0));
    cyc(0, 1, 8'h44);
    cyc(0, 1, 8'h35);
    chk("tmo_then_down5", 32'(hall_down), 32'(7'b0010000));
    cyc(0, 0, 8'h00);

    // Floor byte in the exact expiry cycle wins over the timeout.
    cyc(0, 1, 8'h55);
    for (int j = 1; j <= TMO; j++) cyc(0, 0, 8'h00);
    cyc(0, 1, 8'h34);
    chk("race_up4", 32'(hall_up), 32'(7'b0001000));
    chk("race_no_err", 32'(cmd_error), 32'(0));
    cyc(0, 0, 8'h00);

    // Reset between opcode and digit loses the command.
    cyc(0, 1, 8'h55);
    cyc(1, 0, 8'h00);
    chk("rst_mid_busy", 32'(busy), 32'(0));
    chk("rst_mid_err", 32'(cmd_error), 32'(0));
    cyc(0, 1, 8'h34);
    chk("rst_then_digit_err", 32'(cmd_error), 32'(1));
    chk("rst_then_digit_up", 32'(hall_up), 32'(0));
    cyc(0, 0, 8'h00);
`else
    // Ack held off by tx_ready; bytes during the wait are dropped.
    rdy_drv = 1'b0;
    cyc(0, 1, 8'h43);
    cyc(0, 1, 8'h32);
    chk("ack_car2", 32'(car_call), 32'(7'b0000010));
    for (int j = 0; j < 50; j++) cyc(0, (j % 7) == 0, 8'h44);
    chk("ack_wait_no_tx", 32'(tx_en), 32'(0));
    chk("ack_wait_busy", 32'(busy), 32'(1));
    rdy_drv = 1'b1;
    #1;
    chk("ack_tx_en", 32'(tx_en), 32'(1));
    chk("ack_tx_data", 32'(tx_data), 32'(8'h21));
    cyc(0, 0, 8'h00);
    chk("ack_done_tx", 32'(tx_en), 32'(0));
    chk("ack_done_busy", 32'(busy), 32'(0));
    cyc(0, 1, 8'h5A);
    chk("nak_err", 32'(cmd_error), 32'(1));
    chk("nak_tx_data", 32'(tx_data), 32'(8'h3F));
    cyc(0, 0, 8'h00);
`endif

    // Random byte stream with occasional long gaps, resets and sender stalls.
    for (int i = 0; i < 4000; i++) begin
      logic [7:0] b;
      bit         v;
      case ($urandom_range(0, 4))
        0, 1:    b = 8'(8'h30 + $urandom_range(0, 9));
        2: begin
          case ($urandom_range(0, 5))
            0: b = 8'h43; 1: b = 8'h63; 2: b = 8'h55;
            3: b = 8'h75; 4: b = 8'h44; default: b = 8'h64;
          endcase
        end
        3: begin
          case ($urandom_range(0, 2))
            0: b = 8'h0D; 1: b = 8'h0A; default: b = 8'h20;
          endcase
        end
        default: b = 8'($urandom);
      endcase
      v = ($urandom_range(0, 2) == 0);
      if (ACK_EN) rdy_drv = ($urandom_range(0, 3) != 0);
      if ($urandom_range(0, 199) == 0) begin
        for (int j = 0; j < TMO + int'($urandom_range(0, 2)); j++) cyc(0, 0, 8'h00);
      end
      cyc($urandom_range(0, 599) == 0, v, b);
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
